// File: rtl/stack_cmd_sequencer.sv
// Host-side sequencer for a 5-entry LIFO stack: validates PUSH/POP/GET/NOP, drives the stack bus, returns one response per request.
// Optional STACK_SEQ_STATS_EN adds err_cnt/op_cnt statistics outputs.
module stack_cmd_sequencer #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  input  logic [IDX_W-1:0] req_index,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [2:0]       count,
  output logic             stk_reset,
  output logic [1:0]       stk_command,
  output logic [IDX_W-1:0] stk_index,
  inout  wire  [WIDTH-1:0] stk_io_data
`ifdef STACK_SEQ_STATS_EN
  ,
  output logic [7:0]       err_cnt,
  output logic [7:0]       op_cnt
`endif
);

  // state  | meaning
  // IDLE   | ready for a host request
  // ISSUE  | command on the stack bus for one cycle
  // RESP   | response held until host accepts it
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_GET  = 2'b11;
  localparam logic [2:0] FULL    = 3'(DEPTH);

  state_t           state;
  logic [1:0]       op_q;
  logic             legal_q;
  logic             drive_en;
  logic [WIDTH-1:0] drive_data;
  logic [WIDTH-1:0] rd_cap;
  logic             legal;
  logic             accept;

  assign stk_reset   = ~reset_n;
  assign stk_io_data = drive_en ? drive_data : {WIDTH{1'bz}};
  assign accept      = (state == S_IDLE) && req_ready && req_valid;

  always_comb begin
    legal = 1'b1;
    case (req_op)
      OP_PUSH: legal = (count != FULL);
      OP_POP:  legal = (count != 3'd0);
      OP_GET:  legal = (32'(req_index) < 32'(count));
      default: legal = 1'b1;
    endcase
  end

  // The stack drives read data during the high phase, so sample it on the falling edge.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n)
      rd_cap <= '0;
    else if (state == S_ISSUE)
      rd_cap <= stk_io_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      legal_q     <= 1'b0;
      count       <= 3'd0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      stk_command <= OP_NOP;
      stk_index   <= '0;
      drive_en    <= 1'b0;
      drive_data  <= '0;
`ifdef STACK_SEQ_STATS_EN
      err_cnt     <= 8'd0;
      op_cnt      <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= ~accept;
          if (accept) begin
            state       <= S_ISSUE;
            op_q        <= req_op;
            legal_q     <= legal;
            stk_command <= legal ? req_op : OP_NOP;
            stk_index   <= (req_op == OP_GET) ? req_index : '0;
            drive_en    <= legal && (req_op == OP_PUSH);
            drive_data  <= req_data;
`ifdef STACK_SEQ_STATS_EN
            op_cnt      <= op_cnt + 8'd1;
`endif
          end
        end
        S_ISSUE: begin
          state       <= S_RESP;
          stk_command <= OP_NOP;
          stk_index   <= '0;
          drive_en    <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_err     <= ~legal_q;
          rsp_data    <= (legal_q && (op_q == OP_POP || op_q == OP_GET)) ? rd_cap : '0;
          if (legal_q && op_q == OP_PUSH)
            count <= count + 3'd1;
          else if (legal_q && op_q == OP_POP)
            count <= count - 3'd1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
`ifdef STACK_SEQ_STATS_EN
            if (rsp_err && err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Scoreboard bench for stack_cmd_sequencer with a behavioural 5-entry LIFO on the stack bus.
module tb_stack_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_data;
  logic [2:0] req_index;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [2:0] count;
  logic       stk_reset;
  logic [1:0] stk_command;
  logic [2:0] stk_index;
  wire  [3:0] stk_io_data;
`ifdef STACK_SEQ_STATS_EN
  logic [7:0] err_cnt;
  logic [7:0] op_cnt;
`endif

  stack_cmd_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .count(count), .stk_reset(stk_reset),
    .stk_command(stk_command), .stk_index(stk_index), .stk_io_data(stk_io_data)
`ifdef STACK_SEQ_STATS_EN
    , .err_cnt(err_cnt), .op_cnt(op_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       e;
    logic [2:0] c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = -10;
  int   hs_cyc = -10;
  logic prev_valid = 1'b0;
  logic saw6 = 1'b0;
  logic cmd_seen = 1'b0;

  // behavioural stack
  logic [3:0] mem [0:4];
  int         sp = 0;
  logic       tb_drv = 1'b0;
  logic [3:0] tb_val = 4'h0;
  assign stk_io_data = tb_drv ? tb_val : 4'bzzzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (stk_command == 2'b10 && sp > 0) begin
      tb_val = mem[sp-1];
      tb_drv = 1'b1;
    end else if (stk_command == 2'b11 && int'(stk_index) < sp) begin
      tb_val = mem[sp-1-int'(stk_index)];
      tb_drv = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (stk_reset)
      sp = 0;
    else if (stk_command == 2'b01 && sp < 5) begin
      mem[sp] = stk_io_data;
      sp++;
    end else if (stk_command == 2'b10 && sp > 0)
      sp--;
    #1 tb_drv = 1'b0;
  end

  // monitor: latency, handshake scoreboard, bus observation flags
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (stk_io_data === 4'd6) saw6 = 1'b1;
      if (stk_command != 2'b00) cmd_seen = 1'b1;
      if (req_valid && req_ready) acc_cyc = cyc + 1;
      if (rsp_valid && !prev_valid) chk("latency", 32'(cyc - acc_cyc), 32'd1);
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        hs_cyc = cyc + 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(mon_e.d));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.e));
          chk("count", 32'(count), 32'(mon_e.c));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [2:0] idx,
                      input logic [3:0] ed, input logic ee, input logic [2:0] ec);
    exp_t e;
    int   n;
    e.d = ed; e.e = ee; e.c = ec;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_data = d; req_index = idx;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rsp_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'b00; req_data = 4'h0; req_index = 3'd0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_stk_cmd", 32'(stk_command), 32'd0);
    chk("rst_stk_reset", 32'(stk_reset), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("run_stk_reset", 32'(stk_reset), 32'd0);

    // PUSH 3,7,9 then POP x3
    send(2'b01, 4'd3, 3'd0, 4'd0, 1'b0, 3'd1);
    send(2'b01, 4'd7, 3'd0, 4'd0, 1'b0, 3'd2);
    send(2'b01, 4'd9, 3'd0, 4'd0, 1'b0, 3'd3);
    send(2'b10, 4'd0, 3'd0, 4'd9, 1'b0, 3'd2);
    send(2'b10, 4'd0, 3'd0, 4'd7, 1'b0, 3'd1);
    send(2'b10, 4'd0, 3'd0, 4'd3, 1'b0, 3'd0);
    wait_idle();

    // POP on empty
    cmd_seen = 1'b0;
    send(2'b10, 4'd0, 3'd0, 4'd0, 1'b1, 3'd0);
    wait_idle();
    chk("empty_pop_cmd", 32'(cmd_seen), 32'd0);
    send(2'b00, 4'd5, 3'd0, 4'd0, 1'b0, 3'd0);
    wait_idle();

    // reset in the middle of a PUSH issue cycle
    send(2'b01, 4'd3, 3'd0, 4'd0, 1'b0, 3'd1);
    send(2'b01, 4'd7, 3'd0, 4'd0, 1'b0, 3'd2);
    wait_idle();
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_data = 4'hA; req_index = 3'd0;
    do @(negedge clk); while (!req_ready);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("issue_bus_driven", 32'(stk_io_data === 4'hA), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_bus", 32'(stk_io_data === 4'hA), 32'd0);
    chk("mid_rst_cmd", 32'(stk_command), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_stk_reset", 32'(stk_reset), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // fill, overflow, GET boundaries
    send(2'b01, 4'd1, 3'd0, 4'd0, 1'b0, 3'd1);
    send(2'b01, 4'd2, 3'd0, 4'd0, 1'b0, 3'd2);
    send(2'b01, 4'd3, 3'd0, 4'd0, 1'b0, 3'd3);
    send(2'b01, 4'd4, 3'd0, 4'd0, 1'b0, 3'd4);
    send(2'b01, 4'd5, 3'd0, 4'd0, 1'b0, 3'd5);
    wait_idle();
    saw6 = 1'b0;
    send(2'b01, 4'd6, 3'd0, 4'd0, 1'b1, 3'd5);
    wait_idle();
    chk("bus_saw_6", 32'(saw6), 32'd0);
    send(2'b11, 4'd0, 3'd4, 4'd1, 1'b0, 3'd5);
    send(2'b11, 4'd0, 3'd0, 4'd5, 1'b0, 3'd5);
    send(2'b11, 4'd0, 3'd5, 4'd0, 1'b1, 3'd5);
    wait_idle();

    // response backpressure with a pending request
    rsp_ready = 1'b0;
    send(2'b10, 4'd0, 3'd0, 4'd5, 1'b0, 3'd4);
    mon_e.d = 4'd4; mon_e.e = 1'b0; mon_e.c = 3'd4;
    exp_q.push_back(mon_e);
    req_valid = 1'b1; req_op = 2'b11; req_data = 4'd0; req_index = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(rsp_data), 32'd5);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!req_ready && n < 50);
      if (n >= 50) chk("pending_accept_timeout", 32'd1, 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pending_accept_delay", 32'(acc_cyc - hs_cyc), 32'd1);
    wait_idle();

`ifdef STACK_SEQ_STATS_EN
    do_reset();
    chk("stats_rst_err", 32'(err_cnt), 32'd0);
    chk("stats_rst_op", 32'(op_cnt), 32'd0);
    for (int i = 0; i < 260; i++)
      send(2'b10, 4'd0, 3'd0, 4'd0, 1'b1, 3'd0);
    wait_idle();
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    chk("op_cnt_wrap", 32'(op_cnt), 32'd4);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
